// File: rtl/dpram_clr_if.sv
// dpram_clr_if -- host-side bundle for the clearable dual-port RAM.
//   data, wraddress, wren : write port (host -> RAM)
//   rdaddress, rden       : read request (host -> RAM)
//   clear                 : start a full-memory clear (host -> RAM)
//   busy                  : clear engine running (RAM -> host)
//   q, q_valid            : read data and its one-cycle valid pulse (RAM -> host)
// The host drives through the master modport; the RAM uses the slave modport.
interface dpram_clr_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] data;
  logic [ADDR_WIDTH-1:0] wraddress;
  logic                  wren;
  logic [ADDR_WIDTH-1:0] rdaddress;
  logic                  rden;
  logic                  clear;
  logic                  busy;
  logic [DATA_WIDTH-1:0] q;
  logic                  q_valid;

  modport master (
    output data, wraddress, wren, rdaddress, rden, clear,
    input  busy, q, q_valid
  );

  modport slave (
    input  data, wraddress, wren, rdaddress, rden, clear,
    output busy, q, q_valid
  );
endinterface

// File: rtl/dpram_clr.sv
// dpram_clr -- simple dual-port RAM (one write port, one read port, one
// clock) with a built-in engine that overwrites every word with CLEAR_VALUE.
//   clock   : sole clock, rising edge
//   reset_n : asynchronous active-low reset (memory contents are kept)
//   bus     : dpram_clr_if slave modport carrying write, read, clear,
//             busy, q and q_valid
// Parameters: DATA_WIDTH word width, ADDR_WIDTH address width (depth is
// 2**ADDR_WIDTH), OUT_REG adds a second output stage (read latency 2),
// CLEAR_VALUE is the word written by the clear engine.
module dpram_clr #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    OUT_REG     = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic       clock,
  input  logic       reset_n,
  dpram_clr_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  host_ok;
  logic                  rd_accept;
  logic                  rd_fwd;
  logic [DATA_WIDTH-1:0] s1_q;
  logic                  s1_valid;

  // Host traffic is only honoured while the clear engine is idle.
  assign host_ok   = (state == IDLE);
  assign rd_accept = host_ok && bus.rden;
  assign rd_fwd    = bus.wren && (bus.wraddress == bus.rdaddress);
  assign bus.busy  = (state == CLEAR);

  // Clear FSM state register; reset aborts any clear in progress.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: start on a sampled clear level, finish after the
  // last address has been written.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.clear) state_next = CLEAR;
      CLEAR:   if (clr_addr == '1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Clear address counter: held at zero while idle so the first CLEAR cycle
  // targets address 0; it wraps back to zero after the last word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clr_addr <= '0;
    end else if (state == CLEAR) begin
      clr_addr <= clr_addr + ADDR_WIDTH'(1);
    end else begin
      clr_addr <= '0;
    end
  end

  // Memory write port. No reset here: contents survive reset_n, and a
  // host write on the edge that starts a clear still lands before the
  // engine overwrites it.
  always_ff @(posedge clock) begin
    if (state == CLEAR) begin
      mem[clr_addr] <= CLEAR_VALUE;
    end else if (bus.wren) begin
      mem[bus.wraddress] <= bus.data;
    end
  end

  // First read stage. A read hitting the address being written on the same
  // edge returns the incoming data (write-first). q holds between reads.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_q     <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= rd_accept;
      if (rd_accept) begin
        s1_q <= rd_fwd ? bus.data : mem[bus.rdaddress];
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] s2_q;
      logic                  s2_valid;

      // Optional second stage: forwards each stage-1 result one cycle
      // later, keeping one pulse per read and full throughput.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          s2_q     <= '0;
          s2_valid <= 1'b0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_q <= s1_q;
          end
        end
      end

      assign bus.q       = s2_q;
      assign bus.q_valid = s2_valid;
    end else begin : g_no_out_reg
      assign bus.q       = s1_q;
      assign bus.q_valid = s1_valid;
    end
  endgenerate

endmodule

// File: doc/dpram_clr.md
DPRAM_CLR -- requirements
Module: dpram_clr

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of each memory word and of data/q.
REQ-002 Parameter ADDR_WIDTH, default 16, address width; depth SHALL be 2**ADDR_WIDTH words.
REQ-003 Parameter OUT_REG, default 0, 0 = read latency 1 cycle, 1 = extra output register stage, latency 2 cycles.
REQ-004 Parameter CLEAR_VALUE, default 0, DATA_WIDTH-bit word written to every location by the clear engine.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset; all other logic is synchronous to the rising edge of clock.
REQ-006 clock  input  1  sole clock.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 data  input  DATA_WIDTH  write data.
REQ-009 wraddress  input  ADDR_WIDTH  write address.
REQ-010 wren  input  1  write enable.
REQ-011 rdaddress  input  ADDR_WIDTH  read address.
REQ-012 rden  input  1  read enable.
REQ-013 clear  input  1  start full-memory clear; level sampled in IDLE.
REQ-014 busy  output  1  high while the clear engine runs.
REQ-015 q  output  DATA_WIDTH  read data.
REQ-016 q_valid  output  1  single-cycle pulse marking a new q value.

Function
REQ-017 Write: on a rising edge with wren=1 and busy=0, mem[wraddress] SHALL take data.
REQ-018 Read: on a rising edge with rden=1 and busy=0, rdaddress SHALL be captured; q and q_valid=1 SHALL appear 1 cycle later (OUT_REG=0) or 2 cycles later (OUT_REG=1).
REQ-019 q SHALL hold its last value when no read completes; q_valid SHALL be 0 in cycles with no completing read.
REQ-020 Back-to-back reads SHALL be accepted every cycle with full throughput, one q_valid pulse per accepted read, in order.
REQ-021 Read and write to the same address in the same edge SHALL return the new write data (write-first forwarding); different addresses SHALL be independent.
REQ-022 Clear FSM states: IDLE, CLEAR.
REQ-023 IDLE -> CLEAR on a rising edge with clear=1; internal address counter SHALL load 0 on that edge.
REQ-024 In CLEAR, each cycle SHALL write CLEAR_VALUE to mem[counter] and increment the counter; after writing address 2**ADDR_WIDTH-1 the FSM SHALL return to IDLE and the counter SHALL wrap to 0.
REQ-025 busy SHALL equal 1 exactly while in CLEAR, i.e. for 2**ADDR_WIDTH consecutive cycles.
REQ-026 While busy=1, wren and rden SHALL be ignored (no write, no q_valid); clear SHALL be ignored (no restart).
REQ-027 Reads accepted before the clear starts SHALL still complete with their q_valid pulse, returning pre-clear data.
REQ-028 clear and wren asserted on the same edge in IDLE: the host write SHALL occur, then the clear overwrites it.

Reset
REQ-029 reset_n=0 SHALL immediately force FSM=IDLE, counter=0, busy=0, q=0, q_valid=0, and flush the read pipeline.
REQ-030 Memory contents SHALL NOT be modified by reset; reset mid-clear SHALL abort it, leaving locations already cleared at CLEAR_VALUE and the rest unchanged.
REQ-031 After reset_n rises, the block SHALL accept operations on the first rising edge.

Verification
REQ-032 Write 0xA5 to addr 0x0003, next cycle read 0x0003 (OUT_REG=0) -> q=0xA5 and q_valid=1 one cycle after the read edge.
REQ-033 Same edge: write 0x3C to 0x0010 and read 0x0010 -> q=0x3C (forwarded); repeat with OUT_REG=1 -> q=0x3C two cycles later.
REQ-034 ADDR_WIDTH=4: fill all 16 words with 0xFF, pulse clear -> busy high exactly 16 cycles, then reads of 0..15 all return CLEAR_VALUE 0x00.
REQ-035 ADDR_WIDTH=4, during clear assert wren (addr 2, 0x77), rden, clear -> no write, no q_valid, busy still 16 cycles; addr 2 reads 0x00 afterwards.
REQ-036 ADDR_WIDTH=4, memory 0xFF, assert reset_n=0 after 5 clear cycles -> busy=0, q_valid=0 immediately; addrs 0..4 read 0x00, 5..15 read 0xFF.
REQ-037 Streaming reads of addrs 0..7 on consecutive edges -> 8 consecutive q_valid pulses with data in address order.
